resonator_dds_mix_requant: RTL and testbench
============================================

# resonator_dds_mix_requant

Complex mix-and-requantize stage directly downstream of the 16x16 signed DSP48 multipliers in the resonator DDS datapath. It takes four Q2.30 partial products per sample and forms I = rr − ii and Q = ri + ir. It rounds both half-to-even to Q1.15, saturates them, and emits {Q, I} on an AXI4-Stream master. Backpressure is applied as a global stall through the multipliers' `ce`. The block tracks sample valid/last/user alongside the multiplier pipeline and counts saturation events.

## Interface
- `MUL_LATENCY`, 2: multiplier pipeline depth in ce-qualified cycles; the sideband delay line length.
- `USER_W`, 8: width of the resonator group tag carried in tuser.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  sample presented at the multiplier inputs this cycle.
- `s_last`  in  1  last sample of a group, aligned with s_valid.
- `s_user`  in  USER_W  group tag, aligned with s_valid.
- `pp_rr`, `pp_ii`, `pp_ri`, `pp_ir`  in  32 each  signed multiplier outputs, Q2.30.
- `mul_ce`  out  1  clock enable driven to all four multipliers.
- `m_axis_tdata`  out  32  {Q[15:0], I[15:0]}, signed Q1.15.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  delayed s_last.
- `m_axis_tuser`  out  USER_W  delayed s_user.
- `sat_flag`  out  1  current output sample had I or Q saturated.
- `sat_count`  out  16  saturating count of saturated output samples.
- `sat_clear`  in  1  synchronous clear of sat_count.

## Operation
- Stall: stall = m_axis_tvalid & ~m_axis_tready.
- `mul_ce` = ~stall. This is combinational from tready and is the only combinational in-to-out path.
- All internal registers, including the sideband delay line, advance only when ~stall.
- Sideband delay line: MUL_LATENCY stages of {valid, last, user}. Its output is aligned with the pp_* presented on the same cycle.
- Stage A, registered when ~stall:
  - sumI = sext33(pp_rr) − sext33(pp_ii).
  - sumQ = sext33(pp_ri) + sext33(pp_ir).
  - Sideband is registered alongside.
- Stage B, the output register, loads when ~stall:
  - Round each 33-bit sum half-to-even at bit 15: r = (sum + 0x3FFF + sum[15]) >>> 15, giving an 18-bit result.
  - Saturate r to [−32768, 32767].
  - A sample saturates if either I or Q was clipped; sat_flag is set for that sample.
- m_axis_tvalid is stage-B valid; tdata, tlast and tuser hold while stalled.
- Invalid samples still propagate through the pipeline, but:
  - sat_flag is forced to 0 for them.
  - they never increment sat_count.
- sat_count increments by 1 on each output handshake (tvalid & tready) with sat_flag=1. It stops at 0xFFFF.
- sat_clear has priority over increment: the next value is 0.

## Timing
- Latency: s_valid at cycle t appears on m_axis_tvalid at t + MUL_LATENCY + 2, with no stalls.
- Throughput: one sample per cycle while tready=1.
- Each stall cycle adds exactly one cycle of latency to every in-flight sample. No sample is lost or duplicated.
- The upstream producer must hold s_valid/s_last/s_user and the multiplier inputs while mul_ce=0.
- Reset values:
  - mul_ce=1.
  - m_axis_tvalid=0, tdata=0, tlast=0, tuser=0.
  - sat_flag=0, sat_count=0.
  - All delay-line and stage-A valids are 0.
- Reset asserted mid-stream discards all in-flight samples. The first output after release obeys full latency.
- tready dropping while tvalid=0 causes no stall: bubbles are squeezed out.

## Test plan
- Basic mix:
  - Stimulus: rr=0x20000000, ii=0x10000000, ri=0x08000000, ir=0x08000000, tready=1.
  - Response: tdata=0x20002000 at t+4, sat_flag=0.
- Round half-even:
  - Stimulus: sumI of 0x4000, 0xC000, −0x4000, −0xC000 (via rr, ii=0).
  - Response: I = 0x0000, 0x0002, 0x0000, 0xFFFE.
- Saturation:
  - Stimulus: ri=ir=0x40000000, then rr=0x80000000 with ii=0x40000000.
  - Response: Q=0x7FFF, then I=0x8000. sat_flag=1 on both; sat_count=2.
- Backpressure:
  - Stimulus: 16-sample burst with s_last on sample 16; tready toggles with a pseudo-random pattern.
  - Response: mul_ce=~(tvalid&~tready) every cycle; all 16 samples arrive in order, unduplicated; tlast only on the 16th; tuser preserved.
- Reset mid-stream:
  - Stimulus: reset_n low for 1 cycle with 3 samples in flight.
  - Response: tvalid=0 immediately; no stale samples emerge; the next input appears after 4 cycles.
- Counter:
  - Stimulus: 0x10005 saturated handshakes, then sat_clear concurrent with a saturated handshake.
  - Response: sat_count reaches 0xFFFF and holds, then reads 0.

Source files
------------

// File: rtl/resonator_dds_mix_requant.sv
// Complex mix of DSP48 partial products (I = rr - ii, Q = ri + ir), half-to-even requantization
// to Q1.15 with saturation, AXI4-Stream output; backpressure stalls the multipliers through mul_ce.
module resonator_dds_mix_requant #(
   parameter int MUL_LATENCY = 2,
   parameter int USER_W      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   input  logic              s_last,
   input  logic [USER_W-1:0] s_user,
   input  logic [31:0]       pp_rr,
   input  logic [31:0]       pp_ii,
   input  logic [31:0]       pp_ri,
   input  logic [31:0]       pp_ir,
   output logic              mul_ce,
   output logic [31:0]       m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic [USER_W-1:0] m_axis_tuser,
   output logic              sat_flag,
   output logic [15:0]       sat_count,
   input  logic              sat_clear
);

   // Returns {clipped, value}: round half-to-even at bit 15, then clip to the Q1.15 range.
   function automatic logic [16:0] requant(input logic [32:0] sum);
      logic signed [33:0] ext_s;
      logic signed [33:0] bias_s;
      logic signed [33:0] biased_s;
      logic signed [18:0] r_s;
      logic [16:0]        res_s;
      ext_s    = {sum[32], sum};
      bias_s   = {20'd0, 14'h3FFF} + {33'd0, sum[15]};
      biased_s = ext_s + bias_s;
      r_s      = biased_s[33:15];
      if (r_s > 19'sd32767) begin
         res_s = {1'b1, 16'h7FFF};
      end else if (r_s < -19'sd32768) begin
         res_s = {1'b1, 16'h8000};
      end else begin
         res_s = {1'b0, r_s[15:0]};
      end
      return res_s;
   endfunction

   logic                                stall_s;
   logic                                hs_s;
   logic [MUL_LATENCY-1:0]              dl_valid_r;
   logic [MUL_LATENCY-1:0]              dl_last_r;
   logic [MUL_LATENCY-1:0][USER_W-1:0]  dl_user_r;
   logic [MUL_LATENCY:0]                dl_valid_s;
   logic [MUL_LATENCY:0]                dl_last_s;
   logic [MUL_LATENCY:0][USER_W-1:0]    dl_user_s;
   logic                                a_valid_r;
   logic                                a_last_r;
   logic [USER_W-1:0]                   a_user_r;
   logic [32:0]                         a_sum_i_r;
   logic [32:0]                         a_sum_q_r;
   logic [16:0]                         req_i_s;
   logic [16:0]                         req_q_s;

   // Global stall: only a held output sample that downstream refuses blocks the pipe.
   assign stall_s = m_axis_tvalid & ~m_axis_tready;
   assign mul_ce  = ~stall_s;
   assign hs_s    = m_axis_tvalid & m_axis_tready;

   assign dl_valid_s = {dl_valid_r, s_valid};
   assign dl_last_s  = {dl_last_r, s_last};
   assign dl_user_s  = {dl_user_r, s_user};

   // Sideband delay line matching the multiplier pipeline depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_valid_r <= '0;
         dl_last_r  <= '0;
         dl_user_r  <= '0;
      end else if (!stall_s) begin
         dl_valid_r <= dl_valid_s[MUL_LATENCY-1:0];
         dl_last_r  <= dl_last_s[MUL_LATENCY-1:0];
         dl_user_r  <= dl_user_s[MUL_LATENCY-1:0];
      end
   end

   // Stage A: full-precision complex mix with sideband.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_valid_r <= 1'b0;
         a_last_r  <= 1'b0;
         a_user_r  <= '0;
         a_sum_i_r <= 33'd0;
         a_sum_q_r <= 33'd0;
      end else if (!stall_s) begin
         a_valid_r <= dl_valid_r[MUL_LATENCY-1];
         a_last_r  <= dl_last_r[MUL_LATENCY-1];
         a_user_r  <= dl_user_r[MUL_LATENCY-1];
         a_sum_i_r <= {pp_rr[31], pp_rr} - {pp_ii[31], pp_ii};
         a_sum_q_r <= {pp_ri[31], pp_ri} + {pp_ir[31], pp_ir};
      end
   end

   // Requantize both rails from stage A.
   always_comb begin
      req_i_s = requant(a_sum_i_r);
      req_q_s = requant(a_sum_q_r);
   end

   // Stage B: output register; holds everything while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 32'd0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
         sat_flag      <= 1'b0;
      end else if (!stall_s) begin
         m_axis_tvalid <= a_valid_r;
         m_axis_tdata  <= {req_q_s[15:0], req_i_s[15:0]};
         m_axis_tlast  <= a_last_r;
         m_axis_tuser  <= a_user_r;
         sat_flag      <= a_valid_r & (req_i_s[16] | req_q_s[16]);
      end
   end

   // Saturation event counter; clear wins over increment, sticks at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sat_count <= 16'd0;
      end else if (sat_clear) begin
         sat_count <= 16'd0;
      end else if (hs_s && sat_flag && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_resonator_dds_mix_requant.sv
// Self-checking bench for resonator_dds_mix_requant: directed and randomized samples compared
// against an arithmetic reference model through an in-order scoreboard.
module tb_resonator_dds_mix_requant;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [7:0]  user;
      logic        sat;
      int          ce_idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        s_valid;
   logic        s_last;
   logic [7:0]  s_user;
   logic [31:0] pp_rr, pp_ii, pp_ri, pp_ir;
   logic        mul_ce;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [7:0]  m_axis_tuser;
   logic        sat_flag;
   logic [15:0] sat_count;
   logic        sat_clear;

   logic [31:0] in_pp [4];
   logic [31:0] m0 [4];
   logic [31:0] m1 [4];

   exp_t        sb[$];
   int          nchk = 0;
   int          nfail = 0;
   int          ce_edges = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic        last_acc = 1'b0;
   logic        rnd_ready = 1'b0;

   resonator_dds_mix_requant #(.MUL_LATENCY(2), .USER_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_valid(s_valid), .s_last(s_last), .s_user(s_user),
      .pp_rr(pp_rr), .pp_ii(pp_ii), .pp_ri(pp_ri), .pp_ir(pp_ir),
      .mul_ce(mul_ce),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .sat_flag(sat_flag), .sat_count(sat_count), .sat_clear(sat_clear)
   );

   always #5 clk = ~clk;

   // Two-deep multiplier stand-in, clock-enabled by mul_ce like the real DSP48s.
   always @(posedge clk) begin
      if (mul_ce) begin
         m0 <= in_pp;
         m1 <= m0;
      end
   end
   assign pp_rr = m1[0];
   assign pp_ii = m1[1];
   assign pp_ri = m1[2];
   assign pp_ir = m1[3];

   // Returns {clipped, value}: nearest integer of s/2^15, ties to even, clipped to 16-bit signed.
   function automatic logic [16:0] rq(input longint s);
      longint q, rem;
      q   = s >>> 15;
      rem = s - q * 32768;
      if (rem > 16384 || (rem == 16384 && q[0])) q = q + 1;
      if (q > 32767) return {1'b1, 16'h7FFF};
      if (q < -32768) return {1'b1, 16'h8000};
      return {1'b0, q[15:0]};
   endfunction

   function automatic exp_t model(input logic [31:0] rr, ii, ri, ir, input logic l, input logic [7:0] u);
      exp_t e;
      logic [16:0] vi, vq;
      vi = rq(longint'($signed(rr)) - longint'($signed(ii)));
      vq = rq(longint'($signed(ri)) + longint'($signed(ir)));
      e.data = {vq[15:0], vi[15:0]};
      e.sat = vi[16] | vq[16];
      e.last = l;
      e.user = u;
      e.ce_idx = 0;
      return e;
   endfunction

   function automatic logic [31:0] rpp();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = {{6{v[31]}}, v[25:0]};
      return v;
   endfunction

   task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
      nchk++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: check outputs at negedge, update the model at posedge, check counter after it.
   task automatic tick();
      exp_t e, ne;
      logic want_ce, hs, hs_sat, acc, ce_now;
      @(negedge clk);
      want_ce = ~(m_axis_tvalid & ~m_axis_tready);
      chk(64'(mul_ce), 64'(want_ce), "mul_ce");
      if (!m_axis_tvalid) chk(64'(sat_flag), 64'd0, "sat_flag_idle");
      hs = m_axis_tvalid & m_axis_tready;
      hs_sat = 1'b0;
      if (hs) begin
         nchk++;
         assert (sb.size() != 0) else begin
            nfail++;
            $error("FAIL stale_output: observed tdata %08h, expected no output", m_axis_tdata);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(64'(m_axis_tdata), 64'(e.data), "tdata");
            chk(64'(m_axis_tlast), 64'(e.last), "tlast");
            chk(64'(m_axis_tuser), 64'(e.user), "tuser");
            chk(64'(sat_flag), 64'(e.sat), "sat_flag");
            chk(64'(ce_edges), 64'(e.ce_idx), "latency");
            hs_sat = e.sat;
         end
      end
      ce_now = mul_ce;
      acc = mul_ce & s_valid;
      if (acc) ne = model(in_pp[0], in_pp[1], in_pp[2], in_pp[3], s_last, s_user);
      @(posedge clk);
      if (ce_now) ce_edges++;
      if (acc) begin
         ne.ce_idx = ce_edges + 3;
         sb.push_back(ne);
      end
      if (sat_clear) exp_cnt = 16'd0;
      else if (hs_sat && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      last_acc = acc;
      #1;
      chk(64'(sat_count), 64'(exp_cnt), "sat_count");
      if (rnd_ready) m_axis_tready = 1'($urandom);
   endtask

   task automatic send(input logic [31:0] a, b, c, d, input logic l, input logic [7:0] u);
      int n = 0;
      s_valid = 1'b1;
      s_last = l;
      s_user = u;
      in_pp[0] = a; in_pp[1] = b; in_pp[2] = c; in_pp[3] = d;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 200);
      chk(64'(last_acc), 64'd1, "send_accept");
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      chk(64'(sb.size()), 64'd0, "drain");
   endtask

   initial begin
      reset_n = 1'b0;
      s_valid = 1'b0;
      s_last = 1'b0;
      s_user = 8'd0;
      sat_clear = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 4; i++) in_pp[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk(64'(m_axis_tvalid), 64'd0, "rst_tvalid");
      chk(64'(m_axis_tdata), 64'd0, "rst_tdata");
      chk(64'(m_axis_tlast), 64'd0, "rst_tlast");
      chk(64'(m_axis_tuser), 64'd0, "rst_tuser");
      chk(64'(sat_flag), 64'd0, "rst_sat_flag");
      chk(64'(sat_count), 64'd0, "rst_sat_count");
      chk(64'(mul_ce), 64'd1, "rst_mul_ce");
      reset_n = 1'b1;
      repeat (2) tick();

      // Basic mix with exact wall-clock latency.
      send(32'h2000_0000, 32'h1000_0000, 32'h0800_0000, 32'h0800_0000, 1'b0, 8'h11);
      repeat (2) tick();
      chk(64'(m_axis_tvalid), 64'd0, "basic_early");
      tick();
      chk(64'(m_axis_tvalid), 64'd1, "basic_tvalid");
      chk(64'(m_axis_tdata), 64'h2000_2000, "basic_tdata");
      chk(64'(sat_flag), 64'd0, "basic_sat");
      drain();

      // Half-to-even ties on I.
      send(32'h0000_4000, 32'd0, 32'd0, 32'd0, 1'b0, 8'h21);
      send(32'h0000_C000, 32'd0, 32'd0, 32'd0, 1'b0, 8'h22);
      send(32'hFFFF_C000, 32'd0, 32'd0, 32'd0, 1'b0, 8'h23);
      send(32'hFFFF_4000, 32'd0, 32'd0, 32'd0, 1'b0, 8'h24);
      drain();

      // Saturation on Q then on I.
      send(32'd0, 32'd0, 32'h4000_0000, 32'h4000_0000, 1'b0, 8'h31);
      send(32'h8000_0000, 32'h4000_0000, 32'd0, 32'd0, 1'b0, 8'h32);
      drain();
      chk(64'(sat_count), 64'd2, "sat_count_two");

      // 16-sample burst under random backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 16; i++) send(rpp(), rpp(), rpp(), rpp(), (i == 15), 8'(i + 64));
      drain();

      // Longer random run with input gaps.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         send(rpp(), rpp(), rpp(), rpp(), 1'($urandom), 8'($urandom));
      end
      drain();
      rnd_ready = 1'b0;
      m_axis_tready = 1'b1;
      tick();

      // Reset with samples in flight.
      for (int i = 0; i < 3; i++) send(rpp(), rpp(), rpp(), rpp(), 1'b0, 8'(i + 128));
      reset_n = 1'b0;
      #1;
      chk(64'(m_axis_tvalid), 64'd0, "midrst_tvalid");
      chk(64'(mul_ce), 64'd1, "midrst_mul_ce");
      sb.delete();
      exp_cnt = 16'd0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (6) tick();
      send(32'h0123_4567, 32'h0012_3456, 32'h0001_0000, 32'h0002_0000, 1'b1, 8'hA5);
      drain();

      // Counter saturation, then clear concurrent with a saturated handshake.
      for (int i = 0; i < 65545; i++) send(32'd0, 32'd0, 32'h4000_0000, 32'h4000_0000, 1'b0, 8'(i));
      chk(64'(sat_count), 64'hFFFF, "count_hold");
      sat_clear = 1'b1;
      tick();
      sat_clear = 1'b0;
      chk(64'(sat_count), 64'd0, "count_clear");
      drain();

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
